// File: rtl/axilite_csr_pkg.sv
// ============================================================================
// Module   : axilite_csr_pkg
// Brief    : Shared types and helpers for the AXI4-Lite CSR read/write paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axilite_csr_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axil_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } rd_state_t;

    // Word index of a byte address; callers keep as many low bits as they need.
    function automatic logic [31:0] csr_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/axilite_csr_read_data.sv
// ============================================================================
// Module   : axilite_csr_read_data
// Brief    : AXI4-Lite read-data responder in front of the CSR register file.
//            Define AXIL_CSR_RD_SLVERR_EN to answer decode misses with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axilite_csr_read_data
    import axilite_csr_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        addr_good,
    input  logic                        arvalid,
    output logic                        arready,
    output logic                        deassert_addr,
    output logic                        csr_rd_en,
    output logic [$clog2(NUM_REGS)-1:0] csr_rd_addr,
    input  logic [DATA_W-1:0]           csr_rd_data,
    output logic [DATA_W-1:0]           rdata,
    output logic [1:0]                  rresp,
    output logic                        rvalid,
    input  logic                        rready
);

    localparam int         c_idx_w     = $clog2(NUM_REGS);
    localparam logic [1:0] c_wait_init = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

`ifdef AXIL_CSR_RD_SLVERR_EN
    localparam axil_resp_t c_miss_resp = RESP_SLVERR;
`else
    localparam axil_resp_t c_miss_resp = RESP_OKAY;
`endif

    rd_state_t          r_state;
    logic [1:0]         r_cnt;
    logic               r_arready;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    axil_resp_t         r_rresp;

    logic [31:0]        w_index;
    logic               w_unused_index;
    logic               w_ar_hs;

    assign w_index        = csr_index(32'(addr));
    assign w_unused_index = ^w_index[31:c_idx_w];
    assign w_ar_hs        = arvalid && r_arready;

    // NUM_REGS is a power of two, so the sliced index is always in range and
    // addr_good alone decides a hit. Strobes fire in the handshake cycle so
    // that zero-latency register files can be captured on the same edge.
    assign deassert_addr = w_ar_hs;
    assign csr_rd_en     = w_ar_hs && addr_good;
    assign csr_rd_addr   = w_index[c_idx_w-1:0];

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        if (addr_good) begin
                            if (RD_LATENCY == 0) begin
                                r_rdata  <= csr_rd_data;
                                r_rresp  <= RESP_OKAY;
                                r_rvalid <= 1'b1;
                                r_state  <= RESP;
                            end else begin
                                r_cnt   <= c_wait_init;
                                r_state <= WAIT;
                            end
                        end else begin
                            r_rdata  <= '0;
                            r_rresp  <= c_miss_resp;
                            r_rvalid <= 1'b1;
                            r_state  <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rdata  <= csr_rd_data;
                        r_rresp  <= RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (r_rvalid && rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axilite_csr_read_data.sv
// ============================================================================
// Module   : tb_axilite_csr_read_data
// Brief    : Directed bench for axilite_csr_read_data at read latencies 0, 1, 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axilite_csr_read_data;

`ifdef AXIL_CSR_RD_SLVERR_EN
    localparam logic [1:0] c_miss = 2'b10;
`else
    localparam logic [1:0] c_miss = 2'b00;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_s [3];
    logic [2:0]  good_s;
    logic [2:0]  arvalid_s;
    logic [2:0]  rready_s;
    logic [2:0]  arready_w;
    logic [2:0]  deassert_w;
    logic [2:0]  rd_en_w;
    logic [2:0]  rvalid_w;
    logic [3:0]  rd_addr_w [3];
    logic [31:0] rd_data_w [3];
    logic [31:0] rdata_w   [3];
    logic [1:0]  rresp_w   [3];

    int cyc;
    int n_pass;
    int n_total;
    int last_hs [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] reg_val(input logic [3:0] i);
        if (i == 4'd1) return 32'h5566_7788;
        return 32'hC5A0_0000 | {28'd0, i} | ({28'd0, i} << 12);
    endfunction

    for (genvar d = 0; d < 3; d++) begin : g_dut
        localparam int L = (d == 0) ? 0 : ((d == 1) ? 1 : 3);

        axilite_csr_read_data #(
            .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .RD_LATENCY(L)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .addr         (addr_s[d]),
            .addr_good    (good_s[d]),
            .arvalid      (arvalid_s[d]),
            .arready      (arready_w[d]),
            .deassert_addr(deassert_w[d]),
            .csr_rd_en    (rd_en_w[d]),
            .csr_rd_addr  (rd_addr_w[d]),
            .csr_rd_data  (rd_data_w[d]),
            .rdata        (rdata_w[d]),
            .rresp        (rresp_w[d]),
            .rvalid       (rvalid_w[d]),
            .rready       (rready_s[d])
        );

        // Register-file model: data is only valid exactly L cycles after the strobe.
        if (L == 0) begin : g_comb
            assign rd_data_w[d] = reg_val(rd_addr_w[d]);
        end else begin : g_pipe
            logic [31:0] pipe [L];
            always @(posedge clk) begin
                pipe[0] <= rd_en_w[d] ? reg_val(rd_addr_w[d]) : 32'hDEAD_BEEF;
                for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
            end
            assign rd_data_w[d] = pipe[L-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    typedef struct {
        int          d;
        logic [31:0] a;
        logic        good;
        logic [31:0] data;
        logic [1:0]  resp;
        int          bp;
        int          lat;
        int          gap;
        bit          hold;
    } vec_t;

    vec_t vecs [12];

    // Entered at a falling edge; returns at a falling edge after the R handshake.
    task automatic do_read(input vec_t v);
        int n;
        int hs_c;
        logic [31:0] a;
        a = v.a;
        addr_s[v.d]    = v.a;
        good_s[v.d]    = v.good;
        arvalid_s[v.d] = 1'b1;
        rready_s[v.d]  = (v.bp == 0);
        #1;
        n = 0;
        while (!arready_w[v.d] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!arready_w[v.d]) begin
            chk("arready_timeout", {31'd0, arready_w[v.d]}, 32'd1);
            arvalid_s[v.d] = 1'b0;
            return;
        end
        chk("deassert_pulse", {31'd0, deassert_w[v.d]}, 32'd1);
        chk("rd_en", {31'd0, rd_en_w[v.d]}, {31'd0, v.good});
        if (v.good) chk("rd_addr", {28'd0, rd_addr_w[v.d]}, {28'd0, a[5:2]});
        @(posedge clk);
        @(negedge clk);
        hs_c = cyc;
        if (!v.hold) arvalid_s[v.d] = 1'b0;
        chk("post_hs_arready", {30'd0, arready_w[v.d], deassert_w[v.d]}, 32'd0);
        if (v.gap > 0) chk("hs_gap", hs_c - last_hs[v.d], v.gap);
        last_hs[v.d] = hs_c;
        n = 0;
        while (!rvalid_w[v.d] && n < 20) begin
            @(negedge clk); n++;
        end
        chk("rvalid_seen", {31'd0, rvalid_w[v.d]}, 32'd1);
        if (v.lat >= 0) chk("latency", cyc - hs_c, v.lat);
        chk("rdata", rdata_w[v.d], v.data);
        chk("rresp", {30'd0, rresp_w[v.d]}, {30'd0, v.resp});
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk);
            chk("bp_valid_arready", {30'd0, rvalid_w[v.d], arready_w[v.d]}, 32'd2);
            chk("bp_data", rdata_w[v.d] ^ {30'd0, rresp_w[v.d]}, v.data ^ {30'd0, v.resp});
        end
        rready_s[v.d] = 1'b1;
        @(negedge clk);
        chk("r_done", {30'd0, rvalid_w[v.d], arready_w[v.d]}, 32'd1);
    endtask

    initial begin
        int errs;
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        for (int d = 0; d < 3; d++) begin
            addr_s[d]  = 32'd0;
            last_hs[d] = 0;
        end
        good_s    = 3'b000;
        arvalid_s = 3'b000;
        rready_s  = 3'b000;

        vecs[0]  = '{1, 32'h0000_0004, 1'b1, 32'h5566_7788, 2'b00, 0, 1, 0, 1'b0};
        vecs[1]  = '{1, 32'h0000_0004, 1'b1, 32'h5566_7788, 2'b00, 5, 1, 0, 1'b0};
        vecs[2]  = '{1, 32'h0000_0100, 1'b0, 32'h0,         c_miss, 0, 0, 0, 1'b0};
        vecs[3]  = '{1, 32'hFFFF_FF3C, 1'b1, reg_val(4'd15), 2'b00, 0, 1, 0, 1'b0};
        vecs[4]  = '{1, 32'h0000_0007, 1'b1, 32'h5566_7788, 2'b00, 0, 1, 0, 1'b0};
        vecs[5]  = '{1, 32'h0000_0100, 1'b0, 32'h0,         c_miss, 2, 0, 0, 1'b0};
        vecs[6]  = '{0, 32'h0000_0000, 1'b1, reg_val(4'd0), 2'b00, 0, 0, 0, 1'b1};
        vecs[7]  = '{0, 32'h0000_0004, 1'b1, 32'h5566_7788, 2'b00, 0, 0, 2, 1'b1};
        vecs[8]  = '{0, 32'h0000_0008, 1'b1, reg_val(4'd2), 2'b00, 0, 0, 2, 1'b0};
        vecs[9]  = '{2, 32'h0000_0000, 1'b1, reg_val(4'd0), 2'b00, 0, 3, 0, 1'b1};
        vecs[10] = '{2, 32'h0000_0004, 1'b1, 32'h5566_7788, 2'b00, 0, 3, 5, 1'b1};
        vecs[11] = '{2, 32'h0000_0008, 1'b1, reg_val(4'd2), 2'b00, 0, 3, 5, 1'b0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_arready", {31'd0, arready_w[d]}, 32'd1);
            chk("rst_rvalid",  {31'd0, rvalid_w[d]}, 32'd0);
            chk("rst_rdata",   rdata_w[d], 32'd0);
            chk("rst_rresp",   {30'd0, rresp_w[d]}, 32'd0);
            chk("rst_rd_en",   {31'd0, rd_en_w[d]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) do_read(vecs[i]);

        // Reset while the latency-3 instance sits in WAIT.
        addr_s[2]    = 32'h0000_0008;
        good_s[2]    = 1'b1;
        rready_s[2]  = 1'b1;
        arvalid_s[2] = 1'b1;
        #1;
        chk("mid_arready", {31'd0, arready_w[2]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid_s[2] = 1'b0;
        chk("mid_in_wait", {30'd0, rvalid_w[2], arready_w[2]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arready", {30'd0, rvalid_w[2], arready_w[2]}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid_w[2] !== 1'b0) errs++;
        end
        chk("mid_no_resp", errs, 32'd0);
        do_read('{2, 32'h0000_000C, 1'b1, reg_val(4'd3), 2'b00, 0, 3, 0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
